// File: rtl/cpx_dest_pktq_if.sv
// Source/core-side bus for one destination CPX packet queue.
// The master drives pushes and stall; the slave (queue) drives issue and full.
interface cpx_dest_pktq_if #(
    parameter int unsigned W = 145
);
    logic         src_req;
    logic         src_atom;
    logic [W-1:0] src_data;
    logic         q_full;
    logic         core_stall;
    logic         cpx_vld;
    logic         cpx_atom;
    logic [W-1:0] cpx_data;

    modport master (
        output src_req, src_atom, src_data, core_stall,
        input  q_full, cpx_vld, cpx_atom, cpx_data
    );

    modport slave (
        input  src_req, src_atom, src_data, core_stall,
        output q_full, cpx_vld, cpx_atom, cpx_data
    );
endinterface

// File: rtl/cpx_dest_pktq.sv
// Per-core CPX return-packet queue: buffers packets, issues one per cycle
// under core stall, and never splits an IFILL atomic pair.
module cpx_dest_pktq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 145
) (
    input  logic                 rclk,
    input  logic                 rst_l,
    cpx_dest_pktq_if.slave       bus,
    output logic                 err_ovf,
    output logic                 err_split,
    output logic [15:0]          stall_cnt
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = W + 1;

    typedef enum logic {
        RUN   = 1'b0,
        PAIR2 = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           cpx_vld_q, cpx_vld_d;
    logic           cpx_atom_q, cpx_atom_d;
    logic [W-1:0]   cpx_data_q, cpx_data_d;
    logic           q_full_q, q_full_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_split_q, err_split_d;
    logic           atom_req_q, atom_req_d;
    logic [15:0]    stall_cnt_q, stall_cnt_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [EW-1:0]  mem_d [DEPTH];

    logic [EW-1:0]  head;
    logic           head_atom;
    logic           eligible;
    logic           pop;
    logic           push_ok;

    // Issue decision and FSM; an atom head needs its partner queued before it may go.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        head_atom   = head[W];
        eligible    = (count_q != '0) && (!head_atom || (count_q >= CW'(2)));
        state_d     = state_q;
        pop         = 1'b0;
        cpx_vld_d   = 1'b0;
        cpx_atom_d  = 1'b0;
        cpx_data_d  = cpx_data_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (eligible && !bus.core_stall) begin
                    pop        = 1'b1;
                    cpx_vld_d  = 1'b1;
                    cpx_atom_d = head_atom;
                    cpx_data_d = head[W-1:0];
                    if (head_atom) begin
                        state_d = PAIR2;
                    end
                end
                if (eligible && bus.core_stall && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
            PAIR2: begin
                // Second half goes out regardless of stall.
                state_d = RUN;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    cpx_vld_d  = 1'b1;
                    cpx_data_d = head[W-1:0];
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Storage, pointers, occupancy and error flags.
    always_comb begin
        push_ok     = bus.src_req && ((count_q != CW'(DEPTH)) || pop);
        err_ovf_d   = err_ovf_q || (bus.src_req && (count_q == CW'(DEPTH)) && !pop);
        wr_ptr_d    = wr_ptr_q + PW'(push_ok);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = count_q + CW'(push_ok) - CW'(pop);
        q_full_d    = (count_d >= CW'(DEPTH - 1));
        atom_req_d  = bus.src_req && bus.src_atom;
        err_split_d = err_split_q || (atom_req_q && !bus.src_req);
        mem_d       = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {bus.src_atom, bus.src_data};
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            state_q     <= RUN;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cpx_vld_q   <= 1'b0;
            cpx_atom_q  <= 1'b0;
            cpx_data_q  <= '0;
            q_full_q    <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_split_q <= 1'b0;
            atom_req_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cpx_vld_q   <= cpx_vld_d;
            cpx_atom_q  <= cpx_atom_d;
            cpx_data_q  <= cpx_data_d;
            q_full_q    <= q_full_d;
            err_ovf_q   <= err_ovf_d;
            err_split_q <= err_split_d;
            atom_req_q  <= atom_req_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload array needs no reset; occupancy gates every read.
    always_ff @(posedge rclk) begin
        mem_q <= mem_d;
    end

    assign bus.cpx_vld  = cpx_vld_q;
    assign bus.cpx_atom = cpx_atom_q;
    assign bus.cpx_data = cpx_data_q;
    assign bus.q_full   = q_full_q;
    assign err_ovf      = err_ovf_q;
    assign err_split    = err_split_q;
    assign stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_cpx_dest_pktq.sv
// Directed bench for cpx_dest_pktq with an in-order packet scoreboard.
module tb_cpx_dest_pktq;
    localparam int unsigned W   = 145;
    localparam int unsigned DEP = 4;
    localparam int unsigned EW  = W + 1;

    logic        rclk;
    logic        rst_l;
    logic        err_ovf;
    logic        err_split;
    logic [15:0] stall_cnt;
    int          checks;
    int          errors;
    logic [EW-1:0] sb[$];

    cpx_dest_pktq_if #(.W(W)) bus ();

    cpx_dest_pktq #(.DEPTH(DEP), .W(W)) dut (
        .rclk      (rclk),
        .rst_l     (rst_l),
        .bus       (bus),
        .err_ovf   (err_ovf),
        .err_split (err_split),
        .stall_cnt (stall_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, EW'(obs), EW'(exp));
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return W'(r);
    endfunction

    task automatic push(input logic atom, input logic [W-1:0] d, input bit keep);
        bus.src_req  = 1'b1;
        bus.src_atom = atom;
        bus.src_data = d;
        if (keep) sb.push_back({atom, d});
    endtask

    task automatic idle();
        bus.src_req  = 1'b0;
        bus.src_atom = 1'b0;
    endtask

    // Every issued packet must match the oldest accepted push.
    always @(negedge rclk) begin
        logic [EW-1:0] e;
        if (rst_l && bus.cpx_vld === 1'b1) begin
            chk("sb_avail", EW'(sb.size() > 0), EW'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cpx_pkt", {bus.cpx_atom, bus.cpx_data}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] b_data;
        logic [W-1:0] p2_data;
        int           budget;
        checks = 0;
        errors = 0;
        rst_l = 1'b0;
        bus.src_req = 1'b0;
        bus.src_atom = 1'b0;
        bus.src_data = '0;
        bus.core_stall = 1'b0;
        tick();
        tick();
        chk1("rst_vld", bus.cpx_vld, 1'b0);
        chk1("rst_atom", bus.cpx_atom, 1'b0);
        chk("rst_data", EW'(bus.cpx_data), '0);
        chk1("rst_qfull", bus.q_full, 1'b0);
        chk1("rst_ovf", err_ovf, 1'b0);
        chk1("rst_split", err_split, 1'b0);
        chk("rst_stall", EW'(stall_cnt), '0);
        rst_l = 1'b1;
        tick();

        // Two back-to-back packets, no stall.
        push(1'b0, rnd_data(), 1'b1);
        tick();
        chk1("t2_c1_vld", bus.cpx_vld, 1'b0);
        b_data = rnd_data();
        push(1'b0, b_data, 1'b1);
        tick();
        idle();
        chk1("t2_c2_vld", bus.cpx_vld, 1'b1);
        tick();
        chk1("t2_c3_vld", bus.cpx_vld, 1'b1);
        tick();
        chk1("t2_c4_vld", bus.cpx_vld, 1'b0);
        chk("t2_hold", EW'(bus.cpx_data), EW'(b_data));

        // Single packet held by five stall cycles.
        push(1'b0, rnd_data(), 1'b1);
        tick();
        idle();
        bus.core_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk1("t3_stalled_vld", bus.cpx_vld, 1'b0);
            tick();
        end
        bus.core_stall = 1'b0;
        chk1("t3_c6_vld", bus.cpx_vld, 1'b0);
        tick();
        chk1("t3_c7_vld", bus.cpx_vld, 1'b1);
        chk("t3_stall_cnt", EW'(stall_cnt), EW'(5));
        tick();

        // Atomic pair; stall rising after the first half does not split it.
        push(1'b1, rnd_data(), 1'b1);
        tick();
        push(1'b0, rnd_data(), 1'b1);
        tick();
        idle();
        tick();
        bus.core_stall = 1'b1;
        chk1("t4_c3_vld", bus.cpx_vld, 1'b1);
        chk1("t4_c3_atom", bus.cpx_atom, 1'b1);
        tick();
        chk1("t4_c4_vld", bus.cpx_vld, 1'b1);
        chk1("t4_c4_atom", bus.cpx_atom, 1'b0);
        tick();
        bus.core_stall = 1'b0;
        chk1("t4_c5_vld", bus.cpx_vld, 1'b0);
        chk("t4_stall_cnt", EW'(stall_cnt), EW'(5));

        // Fill under stall, overflow drop, then wrap the pointers while draining.
        bus.core_stall = 1'b1;
        push(1'b0, rnd_data(), 1'b1);
        tick();
        chk1("t5_c1_qfull", bus.q_full, 1'b0);
        push(1'b0, rnd_data(), 1'b1);
        tick();
        chk1("t5_c2_qfull", bus.q_full, 1'b0);
        push(1'b0, rnd_data(), 1'b1);
        tick();
        chk1("t5_c3_qfull", bus.q_full, 1'b1);
        push(1'b0, rnd_data(), 1'b1);
        tick();
        chk1("t5_c4_qfull", bus.q_full, 1'b1);
        chk1("t5_c4_ovf", err_ovf, 1'b0);
        push(1'b0, rnd_data(), 1'b0);
        tick();
        chk1("t5_c5_ovf", err_ovf, 1'b1);
        chk("t5_stall_cnt", EW'(stall_cnt), EW'(9));
        bus.core_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(1'b0, rnd_data(), 1'b1);
            tick();
        end
        idle();
        budget = 0;
        while ((sb.size() != 0 || bus.cpx_vld !== 1'b0) && budget < 20) begin
            tick();
            budget++;
        end
        chk1("t5_drained", sb.size() == 0, 1'b1);
        chk1("t5_qfull_end", bus.q_full, 1'b0);
        chk("t5_stall_end", EW'(stall_cnt), EW'(9));
        tick();

        // Atom push without a partner: split error, head waits for a later push.
        push(1'b1, rnd_data(), 1'b1);
        tick();
        idle();
        chk1("t6_c1_split", err_split, 1'b0);
        tick();
        chk1("t6_c2_split", err_split, 1'b1);
        chk1("t6_c2_vld", bus.cpx_vld, 1'b0);
        tick();
        tick();
        chk1("t6_c4_vld", bus.cpx_vld, 1'b0);
        tick();
        p2_data = rnd_data();
        push(1'b0, p2_data, 1'b1);
        tick();
        idle();
        chk1("t6_c6_vld", bus.cpx_vld, 1'b0);
        tick();
        chk1("t6_c7_vld", bus.cpx_vld, 1'b1);
        chk1("t6_c7_atom", bus.cpx_atom, 1'b1);
        tick();
        chk1("t6_c8_vld", bus.cpx_vld, 1'b1);
        chk1("t6_c8_atom", bus.cpx_atom, 1'b0);
        chk("t6_stall_cnt", EW'(stall_cnt), EW'(9));
        tick();

        // Reset while the second half of a pair is pending.
        push(1'b1, rnd_data(), 1'b1);
        tick();
        push(1'b0, rnd_data(), 1'b1);
        tick();
        idle();
        tick();
        chk1("t1_c3_atom", bus.cpx_atom, 1'b1);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        sb.delete();
        chk1("t1_vld", bus.cpx_vld, 1'b0);
        chk1("t1_atom", bus.cpx_atom, 1'b0);
        chk("t1_data", EW'(bus.cpx_data), '0);
        chk1("t1_ovf", err_ovf, 1'b0);
        chk1("t1_split", err_split, 1'b0);
        chk("t1_stall", EW'(stall_cnt), '0);
        chk1("t1_qfull", bus.q_full, 1'b0);
        push(1'b0, rnd_data(), 1'b1);
        tick();
        idle();
        chk1("t1_c5_vld", bus.cpx_vld, 1'b0);
        tick();
        chk1("t1_c6_vld", bus.cpx_vld, 1'b1);
        tick();
        chk1("t1_c7_vld", bus.cpx_vld, 1'b0);
        chk1("t1_sb_empty", sb.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
